// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the rv32 core.
//   - RV32 load/store funct3 encodings
//   - lsu_state_t : load/store unit FSM states
//   - lsu_size_t  : effective access size after funct3 decode
//   - access_size : funct3 -> size (unsupported encodings become word)
//   - is_misaligned : alignment check for a given size and addr[1:0]
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, MEM, RESP} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // BU/HU have no store counterpart, so on a store they fall back to word.
    function automatic lsu_size_t access_size(input logic we, input logic [2:0] func3);
        lsu_size_t sz;
        case (func3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = we ? SZ_W : SZ_B;
            F3_HU:   sz = we ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_H:    mis = lo[0];
            SZ_W:    mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: combinational data alignment for the load/store unit.
//   in  we, func3, lane (addr[1:0]), wdata (rs2), rdata (memory read data)
//   out wdata_al  lane-replicated store data
//   out wstrb     byte strobes, 0 for loads
//   out rdata_ext extracted and sign/zero-extended load data
module rv_lsu_align
    import rv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_al,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata_ext
);

    lsu_size_t   sz;
    logic        zext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        sz     = access_size(we, func3);
        zext   = func3[2];
        byte_v = 8'(rdata >> {lane, 3'b000});
        half_v = 16'(rdata >> {lane[1], 4'b0000});
        case (sz)
            SZ_B: begin
                wdata_al  = {4{wdata[7:0]}};
                wstrb     = 4'b0001 << lane;
                rdata_ext = zext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                // addr[0] is ignored: halfword lane is picked by addr[1] only
                wdata_al  = {2{wdata[15:0]}};
                wstrb     = 4'b0011 << {lane[1], 1'b0};
                rdata_ext = zext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                wdata_al  = wdata;
                wstrb     = 4'b1111;
                rdata_ext = rdata;
            end
        endcase
        if (!we) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: MEM-stage load/store unit of the rv32 core.
//   req_*  : access from execute (valid/ready), captured only at the accept edge
//   mem_*  : valid/ready data-memory port; mem_addr is word aligned,
//            mem_rdata is valid in the cycle mem_ready is high
//   stall  : high while not IDLE, freezes the upstream stages
//   done   : one-cycle completion pulse, with wb_wen/wb_rd/wb_data and err
// Optional feature: define RV_LSU_MISALIGN_ERR_EN to complete misaligned
// halfword/word accesses with err=1 and no memory request. Without it err is
// always 0 and low address bits below the access size are ignored.
//
// state | meaning
// IDLE  | accepting; req_ready = 1
// MEM   | memory request outstanding (mem_valid = 1)
// RESP  | done pulse with write-back data / err
module rv_lsu
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              wb_wen,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              err
);

    lsu_state_t        state;
    logic              r_we;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_rd;
    logic [31:0]       rdata_ext;
    logic              misalign;

`ifdef RV_LSU_MISALIGN_ERR_EN
    assign misalign = is_misaligned(access_size(req_we, req_func3), req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);

    // memory-side outputs come straight from the captured request, so they
    // cannot move while a request waits for mem_ready
    assign mem_we   = r_we;
    assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign wb_rd    = r_rd;

    rv_lsu_align u_align (
        .we        (r_we),
        .func3     (r_func3),
        .lane      (r_addr[1:0]),
        .wdata     (r_wdata),
        .rdata     (mem_rdata),
        .wdata_al  (mem_wdata),
        .wstrb     (mem_wstrb),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r_we      <= 1'b0;
            r_func3   <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= 32'h0;
            r_rd      <= 5'd0;
            mem_valid <= 1'b0;
            done      <= 1'b0;
            wb_wen    <= 1'b0;
            wb_data   <= 32'h0;
            err       <= 1'b0;
        end else begin
            done   <= 1'b0;
            wb_wen <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_func3 <= req_func3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rd    <= req_rd;
                        if (misalign) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= MEM;
                            mem_valid <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state     <= RESP;
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                        wb_wen    <= !r_we;
                        if (!r_we) begin
                            wb_data <= rdata_ext;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Load/store unit forming the MEM stage of the rv32 core, directly downstream of the execute stage. It takes the ALU result as the effective address and rs2 as store data, and runs a valid/ready transaction against data memory. It aligns store data and byte strobes, and extracts and sign/zero-extends load data. It returns a one-cycle completion with write-back data for the register file, and holds `stall` high while busy so the fetch/decode/execute stages freeze.

## Interface
- `ADDR_W`, 32, address width of `req_addr`/`mem_addr`
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  execute stage presents an access
- `req_ready`  out  1  LSU idle and accepting
- `req_we`  in  1  1 = store (MemWrite), 0 = load (MemRead)
- `req_func3`  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `req_addr`  in  ADDR_W  effective address (ALU result)
- `req_wdata`  in  32  store data (rs2)
- `req_rd`  in  5  load destination register
- `stall`  out  1  high whenever state is not IDLE
- `mem_valid`  out  1  memory request
- `mem_ready`  in  1  memory accepts; read data valid in the same cycle
- `mem_we`  out  1  write enable
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte strobes (0 for loads)
- `mem_rdata`  in  32  read data
- `done`  out  1  one-cycle pulse per completed access (load or store)
- `wb_wen`  out  1  with `done`: register write for a successful load
- `wb_rd`  out  5  destination register
- `wb_data`  out  32  extended load data
- `err`  out  1  with `done`: misaligned access (see Configuration)

## Operation
- FSM states IDLE, MEM, RESP. `req_ready` = (state == IDLE). `stall` = !IDLE.
- IDLE: when `req_valid && req_ready`, the access is captured in registers (we, func3, addr, wdata, rd). The next state is MEM. With the error feature enabled, a misaligned access goes to RESP with `err` set instead.
- MEM: `mem_valid` is high. On `mem_ready`, a load latches the extracted data, and the FSM goes to RESP. `mem_*` outputs are held stable while `mem_valid && !mem_ready`.
- RESP: `done` is high for one cycle; then IDLE.
- `wb_wen` = load && !err.
- Store alignment, with lane = addr[1:0]:
  - SB: wdata = {4{b}}, wstrb = 0001 << lane.
  - SH: wdata = {2{h}}, wstrb = 0011 << (2*addr[1]).
  - SW: wdata = wdata, wstrb = 1111.
- Load extraction:
  - LB/LBU: byte `rdata[8*lane +: 8]`, sign- or zero-extended.
  - LH/LHU: halfword `rdata[16*addr[1] +: 16]`, extended the same way.
  - LW: word unchanged.
- Unsupported funct3 (011/110/111, or 100/101 on a store) is treated as a word access.
- Reset values: state IDLE (so `req_ready` = 1 and `stall` = 0). `mem_valid`, `mem_we`, `mem_wstrb`, `done`, `wb_wen` and `err` are 0. `mem_addr`, `mem_wdata`, `wb_rd` and `wb_data` are 0.
- Reset mid-transaction abandons the access: `mem_valid` drops after the reset edge and no `done` is produced.

## Timing
- Access accepted at edge N: `mem_valid` is high from cycle N+1.
- `mem_ready` in cycle M: `done`, `wb_data` and `wb_wen` are valid in cycle M+1.
- Minimum latency from accept to `done` is 2 cycles. Minimum issue interval is 3 cycles, because `req_ready` is low in MEM and RESP.
- A misaligned access (error feature enabled) accepted at N gives `done` plus `err` at N+1, with no memory request.
- `req_*` inputs are sampled only at the accept edge. Changes in MEM/RESP are ignored.
- `mem_ready` outside MEM is ignored.

## Configuration
- `RV_LSU_MISALIGN_ERR_EN` defined:
  - Misaligned cases: LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] ≠ 0.
  - These skip memory entirely and complete with `err` = 1 and `wb_wen` = 0.
- Undefined:
  - `err` is tied to 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access always proceeds to memory.

## Structure
- Shared package `rv_pkg` holds:
  - funct3 constants (F3_B/H/W/BU/HU)
  - `lsu_state_t` enum (IDLE, MEM, RESP)
- One combinational sub-module, `rv_lsu_align`, handles store data/strobe generation and load extraction/extension. The FSM and registers live in `rv_lsu`.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `mem_ready` held 1 → `mem_addr` 0x100, `mem_wstrb` 1111, `done` 2 cycles after accept, `wb_wen` = 0.
- SB addr 0x103, wdata 0x000000A5 → `mem_wdata` 0xA5A5A5A5, `mem_wstrb` 1000.
- LB addr 0x102 vs LBU addr 0x102, rdata 0x0080FF00, `mem_ready` delayed 3 cycles (`mem_addr`/`mem_we` stable, `req_ready` low throughout):
  - LB → `wb_data` 0xFFFFFF80, `wb_rd` echoed, `wb_wen` = 1.
  - LBU → `wb_data` 0x00000080.
- LH addr 0x102, rdata 0x8001_1234 → `wb_data` 0xFFFF8001. LHU → `wb_data` 0x00008001.
- LW addr 0x101:
  - With macro → `done` and `err` the cycle after accept, no `mem_valid`.
  - Without macro → `mem_addr` 0x100, normal load.
- `rst` asserted while in MEM → next cycle `mem_valid` = 0 and `req_ready` = 1. No `done`, even if `mem_ready` rises.
